// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master bus arbiter with per-transaction watchdog
//
// Purpose:
//   Grants one of two valid/ready masters (m0 = CPU, m1 = DMA/debug) onto the
//   single slave bus. Each transaction walks IDLE -> GRANT -> RELEASE -> IDLE.
//   A watchdog aborts a transaction whose slave never answers.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   m0*/m1* inputs           Valid, Instr, WriteEnable, Address, DataIn
//   m0DataOut/m0Ready        read data and completion back to master 0
//   m1DataOut/m1Ready        read data and completion back to master 1
//   sValid, sInstr,
//   sWriteEnable, sAddress,
//   sDataOut                 slave bus request, muxed from the granted master
//   sDataIn, sReady          slave read data and completion
//   grant                    one-hot current owner, 00 when idle
//   timeoutErr               one-cycle pulse when the watchdog aborts
module bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0Valid,
  input  logic                  m0Instr,
  input  logic                  m0WriteEnable,
  input  logic [ADDR_WIDTH-1:0] m0Address,
  input  logic [DATA_WIDTH-1:0] m0DataIn,
  output logic [DATA_WIDTH-1:0] m0DataOut,
  output logic                  m0Ready,
  input  logic                  m1Valid,
  input  logic                  m1Instr,
  input  logic                  m1WriteEnable,
  input  logic [ADDR_WIDTH-1:0] m1Address,
  input  logic [DATA_WIDTH-1:0] m1DataIn,
  output logic [DATA_WIDTH-1:0] m1DataOut,
  output logic                  m1Ready,
  output logic                  sValid,
  output logic                  sInstr,
  output logic                  sWriteEnable,
  output logic [ADDR_WIDTH-1:0] sAddress,
  output logic [DATA_WIDTH-1:0] sDataOut,
  input  logic [DATA_WIDTH-1:0] sDataIn,
  input  logic                  sReady,
  output logic [1:0]            grant,
  output logic                  timeoutErr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } stateType;

  // Counter only has to reach TIMEOUT-1; keep at least one bit when disabled.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TLASTI = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TLAST = CW'(TLASTI);

  stateType      state;
  logic          lastGrant;   // 1 = master 1 owned the bus last
  logic [CW-1:0] wdCount;
  logic          aborted;     // watchdog fired; fake completion until release

  logic          grantedValid;
  logic          pickM1;
  logic          respReady;
  logic [DATA_WIDTH-1:0] respData;

  assign grantedValid = grant[1] ? m1Valid : m0Valid;

  // Master 1 wins if it is alone, or on a tie when round-robin says m0 went last.
  assign pickM1 = m1Valid && (!m0Valid || (FIXED_PRIO == 0 && !lastGrant));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= 2'b00;
      lastGrant  <= 1'b1;
      wdCount    <= '0;
      aborted    <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      timeoutErr <= 1'b0;
      case (state)
        IDLE: begin
          wdCount <= '0;
          aborted <= 1'b0;
          if (m0Valid || m1Valid) begin
            state <= GRANT;
            grant <= pickM1 ? 2'b10 : 2'b01;
          end
        end
        GRANT: begin
          if (!grantedValid) begin
            state     <= RELEASE;
            lastGrant <= grant[1];
          end else if (TIMEOUT != 0 && !aborted) begin
            // Saturates at TLAST: once aborted the counter is frozen.
            if (sReady) begin
              wdCount <= '0;
            end else if (wdCount == TLAST) begin
              aborted    <= 1'b1;
              timeoutErr <= 1'b1;
            end else begin
              wdCount <= wdCount + 1'b1;
            end
          end
        end
        RELEASE: begin
          state   <= IDLE;
          grant   <= 2'b00;
          wdCount <= '0;
          aborted <= 1'b0;
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Bus mux follows the registered grant; only the GRANT state drives anything.
  always_comb begin
    sValid       = 1'b0;
    sInstr       = 1'b0;
    sWriteEnable = 1'b0;
    sAddress     = '0;
    sDataOut     = '0;
    m0Ready      = 1'b0;
    m1Ready      = 1'b0;
    m0DataOut    = '0;
    m1DataOut    = '0;
    respReady    = 1'b0;
    respData     = '0;
    if (state == GRANT) begin
      sValid       = grantedValid && !aborted;
      sInstr       = grant[1] ? m1Instr       : m0Instr;
      sWriteEnable = grant[1] ? m1WriteEnable : m0WriteEnable;
      sAddress     = grant[1] ? m1Address     : m0Address;
      sDataOut     = grant[1] ? m1DataIn      : m0DataIn;
      // An aborted transaction completes with zero data so the master moves on.
      respReady    = aborted || sReady;
      respData     = aborted ? '0 : sDataIn;
      if (grant[0]) begin
        m0Ready   = respReady;
        m0DataOut = respData;
      end
      if (grant[1]) begin
        m1Ready   = respReady;
        m1DataOut = respData;
      end
    end
  end

endmodule
